// File: rtl/wback_regfile.sv
// Architectural register file and busy scoreboard at the end of the writeback path.
// Latency: reads and stall are combinational; commits and reserves take effect on the next rising edge.
// Backpressure: stall asks decode to hold while a used source has a write in flight.
// Optional feature: define WBACK_REGFILE_BYPASS_EN to forward the committing write onto the read ports.
module wback_regfile #(
  parameter int NUM_REGS = 256,
  parameter int IDX_W    = 8,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [IDX_W-1:0]  rw,
  input  logic [DATA_W-1:0] data,
  input  logic              finished,
  input  logic              reserve_en,
  input  logic [IDX_W-1:0]  reserve_idx,
  input  logic [IDX_W-1:0]  ra,
  input  logic [IDX_W-1:0]  rb,
  input  logic              use_a,
  input  logic              use_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              stall,
  output logic              halted,
  output logic [CNT_W-1:0]  commit_count
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  // One-hot decodes of the write and reserve indices; out-of-range indices match nothing.
  logic [NUM_REGS-1:0] wr_dec;
  logic [NUM_REGS-1:0] rsv_dec;
  logic                commit_ok;
  logic                reserve_ok;

  logic [DATA_W-1:0]   reg_a;
  logic [DATA_W-1:0]   reg_b;
  logic                busy_a;
  logic                busy_b;
  logic                busy_a_eff;
  logic                busy_b_eff;

  // Decode writeback and reserve targets against the implemented register range.
  always_comb begin
    wr_dec  = '0;
    rsv_dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_dec[i]  = (rw == IDX_W'(i));
      rsv_dec[i] = (reserve_idx == IDX_W'(i));
    end
  end

  assign commit_ok  = write_enable && !halted && (|wr_dec);
  assign reserve_ok = reserve_en && !halted && (|rsv_dec);

  // Register array and busy bits; a same-cycle reserve beats the release from a commit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_ok && wr_dec[i]) begin
          regs[i] <= data;
        end
        if (reserve_ok && rsv_dec[i]) begin
          busy[i] <= 1'b1;
        end else if (commit_ok && wr_dec[i]) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // Commit counter saturates rather than wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commit_count <= '0;
    end else if (commit_ok && (commit_count != {CNT_W{1'b1}})) begin
      commit_count <= commit_count + 1'b1;
    end
  end

  // Sticky halt; a write in the same cycle as finished still commits because halted is still 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
    end else if (finished) begin
      halted <= 1'b1;
    end
  end

  // Read muxes over the implemented registers; unmatched (out-of-range) indices read 0 and not busy.
  always_comb begin
    reg_a  = '0;
    reg_b  = '0;
    busy_a = 1'b0;
    busy_b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ra == IDX_W'(i)) begin
        reg_a  = regs[i];
        busy_a = busy[i];
      end
      if (rb == IDX_W'(i)) begin
        reg_b  = regs[i];
        busy_b = busy[i];
      end
    end
  end

`ifdef WBACK_REGFILE_BYPASS_EN
  logic byp_a;
  logic byp_b;
  logic rsv_a;
  logic rsv_b;

  assign byp_a = commit_ok && (rw == ra);
  assign byp_b = commit_ok && (rw == rb);
  assign rsv_a = reserve_ok && (reserve_idx == ra);
  assign rsv_b = reserve_ok && (reserve_idx == rb);

  // Forward the committing value; the source is free unless a newer producer reserves it now.
  always_comb begin
    data_a     = byp_a ? data : reg_a;
    data_b     = byp_b ? data : reg_b;
    busy_a_eff = byp_a ? rsv_a : busy_a;
    busy_b_eff = byp_b ? rsv_b : busy_b;
  end
`else
  // No forwarding: reads see the pre-write value and busy clears one cycle after the commit.
  always_comb begin
    data_a     = reg_a;
    data_b     = reg_b;
    busy_a_eff = busy_a;
    busy_b_eff = busy_b;
  end
`endif

  assign stall = (use_a && busy_a_eff) || (use_b && busy_b_eff);

endmodule

// File: tb/tb_wback_regfile.sv
// Directed bench for wback_regfile with a 16-entry file so out-of-range indices are reachable.
// Stimulus drives one vector per cycle and queues expected outputs; a negedge monitor checks them.
// Expectations for the forwarding variant follow WBACK_REGFILE_BYPASS_EN.
module tb_wback_regfile;

  logic        clock;
  logic        reset;
  logic        write_enable;
  logic [7:0]  rw;
  logic [31:0] data;
  logic        finished;
  logic        reserve_en;
  logic [7:0]  reserve_idx;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic        use_a;
  logic        use_b;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        stall;
  logic        halted;
  logic [31:0] commit_count;

  wback_regfile #(
    .NUM_REGS(16),
    .IDX_W   (8),
    .DATA_W  (32),
    .CNT_W   (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .write_enable(write_enable),
    .rw          (rw),
    .data        (data),
    .finished    (finished),
    .reserve_en  (reserve_en),
    .reserve_idx (reserve_idx),
    .ra          (ra),
    .rb          (rb),
    .use_a       (use_a),
    .use_b       (use_b),
    .data_a      (data_a),
    .data_b      (data_b),
    .stall       (stall),
    .halted      (halted),
    .commit_count(commit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          step;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  logic chk;
  int   step_no;
  int   total;
  int   bad;

`ifdef WBACK_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic cmp(input string nm, input int stp, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, stp, act, want);
    end
  endtask

  // Monitor: whenever a checked vector is presented, pop its expectation and compare all outputs.
  always @(negedge clock) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty step=%0d got=0 want=1", step_no);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp("data_a",       e.step, data_a,               e.a);
        cmp("data_b",       e.step, data_b,               e.b);
        cmp("stall",        e.step, {31'd0, stall},       {31'd0, e.stall});
        cmp("halted",       e.step, {31'd0, halted},      {31'd0, e.halted});
        cmp("commit_count", e.step, commit_count,         e.cnt);
      end
    end
  end

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic apply(input logic rst, input logic we, input logic [7:0] w_idx, input logic [31:0] d,
                       input logic fin, input logic rsv, input logic [7:0] r_idx,
                       input logic [7:0] a_idx, input logic [7:0] b_idx, input logic ua, input logic ub);
    @(posedge clock);
    #1;
    step_no++;
    chk          = 1'b0;
    reset        = rst;
    write_enable = we;
    rw           = w_idx;
    data         = d;
    finished     = fin;
    reserve_en   = rsv;
    reserve_idx  = r_idx;
    ra           = a_idx;
    rb           = b_idx;
    use_a        = ua;
    use_b        = ub;
  endtask

  task automatic expect_out(input logic [31:0] a, input logic [31:0] b, input logic st,
                            input logic hl, input logic [31:0] cnt);
    exp_t e;
    e.step   = step_no;
    e.a      = a;
    e.b      = b;
    e.stall  = st;
    e.halted = hl;
    e.cnt    = cnt;
    exp_q.push_back(e);
    chk = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; step_no = 0; chk = 1'b0;
    reset = 1'b0; write_enable = 1'b0; rw = '0; data = '0; finished = 1'b0;
    reserve_en = 1'b0; reserve_idx = '0; ra = '0; rb = '0; use_a = 1'b0; use_b = 1'b0;

    // 1: in reset, and just after release
    apply(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 8'd0, 8'd255, 1, 1);
    expect_out(32'h0, 32'h0, 0, 0, 0);
    apply(1, 0, 8'd0, 32'h0, 0, 0, 8'd0, 8'd0, 8'd255, 1, 1);
    expect_out(32'h0, 32'h0, 0, 0, 0);

    // 2: write r5, forwarded only with bypass; visible next cycle
    apply(1, 1, 8'd5, 32'hDEADBEEF, 0, 0, 8'd0, 8'd5, 8'd0, 1, 0);
    expect_out(BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 0, 0, 0);
    apply(1, 0, 8'd0, 32'h0, 0, 0, 8'd0, 8'd5, 8'd5, 1, 1);
    expect_out(32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1);

    // 3: reserve r7, stall while used, release by commit
    apply(1, 0, 8'd0, 32'h0, 0, 1, 8'd7, 8'd7, 8'd5, 0, 1);
    expect_out(32'h0, 32'hDEADBEEF, 0, 0, 1);
    apply(1, 0, 8'd0, 32'h0, 0, 0, 8'd0, 8'd7, 8'd5, 1, 1);
    expect_out(32'h0, 32'hDEADBEEF, 1, 0, 1);
    apply(1, 0, 8'd0, 32'h0, 0, 0, 8'd0, 8'd7, 8'd5, 0, 1);
    expect_out(32'h0, 32'hDEADBEEF, 0, 0, 1);
    apply(1, 1, 8'd7, 32'h12, 0, 0, 8'd0, 8'd7, 8'd5, 1, 0);
    expect_out(BYP ? 32'h12 : 32'h0, 32'hDEADBEEF, BYP ? 1'b0 : 1'b1, 0, 1);
    apply(1, 0, 8'd0, 32'h0, 0, 0, 8'd0, 8'd7, 8'd7, 1, 1);
    expect_out(32'h12, 32'h12, 0, 0, 2);

    // 4: reserve and commit r3 together; busy stays set
    apply(1, 1, 8'd3, 32'h33, 0, 1, 8'd3, 8'd3, 8'd7, 1, 1);
    expect_out(BYP ? 32'h33 : 32'h0, 32'h12, BYP ? 1'b1 : 1'b0, 0, 2);
    apply(1, 0, 8'd0, 32'h0, 0, 0, 8'd0, 8'd3, 8'd7, 1, 1);
    expect_out(32'h33, 32'h12, 1, 0, 3);

    // top in-range index, then out-of-range write/read/reserve
    apply(1, 1, 8'd15, 32'hF00D, 0, 0, 8'd0, 8'd3, 8'd15, 0, 0);
    expect_out(32'h33, BYP ? 32'hF00D : 32'h0, 0, 0, 3);
    apply(1, 1, 8'd20, 32'hBAD, 0, 0, 8'd0, 8'd20, 8'd15, 1, 0);
    expect_out(32'h0, 32'hF00D, 0, 0, 4);
    apply(1, 0, 8'd0, 32'h0, 0, 1, 8'd20, 8'd20, 8'd15, 0, 0);
    expect_out(32'h0, 32'hF00D, 0, 0, 4);
    apply(1, 0, 8'd0, 32'h0, 0, 0, 8'd0, 8'd20, 8'd15, 1, 1);
    expect_out(32'h0, 32'hF00D, 0, 0, 4);

    // 5: finished with a write; later write and reserve ignored, busy frozen
    apply(1, 1, 8'd9, 32'hAA, 1, 0, 8'd0, 8'd9, 8'd3, 0, 0);
    expect_out(BYP ? 32'hAA : 32'h0, 32'h33, 0, 0, 4);
    apply(1, 1, 8'd9, 32'hBB, 0, 1, 8'd5, 8'd9, 8'd3, 0, 1);
    expect_out(32'hAA, 32'h33, 1, 1, 5);
    apply(1, 0, 8'd0, 32'h0, 0, 0, 8'd0, 8'd9, 8'd5, 1, 1);
    expect_out(32'hAA, 32'hDEADBEEF, 0, 1, 5);

    // 6: asynchronous reset mid-cycle, with a write pending that must be lost
    apply(0, 1, 8'd2, 32'h77, 0, 0, 8'd0, 8'd9, 8'd3, 1, 1);
    expect_out(32'h0, 32'h0, 0, 0, 0);
    apply(1, 1, 8'd2, 32'h22, 0, 0, 8'd0, 8'd9, 8'd3, 1, 1);
    expect_out(32'h0, 32'h0, 0, 0, 0);
    apply(1, 0, 8'd0, 32'h0, 0, 0, 8'd0, 8'd2, 8'd3, 1, 1);
    expect_out(32'h22, 32'h0, 0, 0, 1);

    apply(1, 0, 8'd0, 32'h0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 0);
    @(posedge clock);
    @(posedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
